// File: rtl/sp_ram_arbiter_if.sv
// sp_ram_arbiter_if: one requester's command/response bundle toward the shared RAM arbiter.
//   master : requester side (drives req/we/addr/wdata, receives gnt/rvalid/rdata)
//   slave  : arbiter side
//   req    : access request, held with its command until gnt
//   we     : 1 = write, 0 = read
//   addr   : word address
//   wdata  : write data
//   gnt    : combinational accept strobe
//   rvalid : registered read-data valid, one cycle after a read grant
//   rdata  : read data, meaningful only while rvalid is high
interface sp_ram_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: two-port arbiter/sequencer in front of a single-port RAM with a
// one-cycle registered read. Port 0 (instruction fetch) and port 1 (load/store)
// share the RAM; at most one access is granted per cycle.
// Optional feature macro: SP_RAM_ARB_RR_EN (round-robin arbitration; default is
// fixed priority with port 0 winning every conflict).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   p0, p1       : requester bundles (slave modport)
//   ram_rd_ena   : RAM read enable
//   ram_wr_ena   : RAM write enable
//   ram_address  : RAM word address (0 when idle)
//   ram_wr_data  : RAM write data (0 when idle)
//   ram_rd_data  : RAM registered read data
module sp_ram_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  sp_ram_arbiter_if.slave       p0,
  sp_ram_arbiter_if.slave       p1,
  output logic                  ram_rd_ena,
  output logic                  ram_wr_ena,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  // prio: 0 favours port 0, 1 favours port 1
  logic prio_q, prio_d;
  logic rv0_q, rv0_d;
  logic rv1_q, rv1_d;
  logic gnt0, gnt1;

  // Grant decode: a lone requester wins, a conflict goes to the prio port.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt0 = p0.req & (~p1.req | ~prio_q);
      gnt1 = p1.req & (~p0.req |  prio_q);
    end
  end

  assign p0.gnt = gnt0;
  assign p1.gnt = gnt1;

  // RAM command mux; everything parks at zero when nothing is granted.
  always_comb begin
    ram_rd_ena  = 1'b0;
    ram_wr_ena  = 1'b0;
    ram_address = '0;
    ram_wr_data = '0;
    if (gnt0) begin
      ram_rd_ena  = ~p0.we;
      ram_wr_ena  =  p0.we;
      ram_address = p0.addr;
      ram_wr_data = p0.wdata;
    end else if (gnt1) begin
      ram_rd_ena  = ~p1.we;
      ram_wr_ena  =  p1.we;
      ram_address = p1.addr;
      ram_wr_data = p1.wdata;
    end
  end

  // Next state: read tags follow the RAM's one-cycle read, prio per arbitration mode.
  always_comb begin
    prio_d = prio_q;
    rv0_d  = gnt0 & ~p0.we;
    rv1_d  = gnt1 & ~p1.we;
`ifdef SP_RAM_ARB_RR_EN
    // Hand priority to the port that lost; hold when idle.
    if (gnt0) begin
      prio_d = 1'b1;
    end else if (gnt1) begin
      prio_d = 1'b0;
    end
`else
    prio_d = 1'b0;
`endif
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
    end else begin
      prio_q <= prio_d;
      rv0_q  <= rv0_d;
      rv1_q  <= rv1_d;
    end
  end

  // Read data is exposed only in the valid cycle so idle outputs stay at zero.
  assign p0.rvalid = rv0_q;
  assign p1.rvalid = rv1_q;
  assign p0.rdata  = rv0_q ? ram_rd_data : '0;
  assign p1.rdata  = rv1_q ? ram_rd_data : '0;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb_sp_ram_arbiter: directed bench for sp_ram_arbiter with a behavioural
// single-port RAM (one-cycle registered read). Honors SP_RAM_ARB_RR_EN.
module tb_sp_ram_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;

  logic          clk;
  logic          rst;
  logic          ram_rd_ena;
  logic          ram_wr_ena;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_wr_data;
  logic [DW-1:0] ram_rd_data;
  logic [DW-1:0] mem [2**AW];

  int checks;
  int failures;

  sp_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) p0_if ();
  sp_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) p1_if ();

  sp_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .p0          (p0_if),
    .p1          (p1_if),
    .ram_rd_ena  (ram_rd_ena),
    .ram_wr_ena  (ram_wr_ena),
    .ram_address (ram_address),
    .ram_wr_data (ram_wr_data),
    .ram_rd_data (ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM
  always_ff @(posedge clk) begin
    if (ram_wr_ena) mem[ram_address] <= ram_wr_data;
    if (ram_rd_ena) ram_rd_data <= mem[ram_address];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic drive0(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p0_if.req = req; p0_if.we = we; p0_if.addr = a; p0_if.wdata = d;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p1_if.req = req; p1_if.we = we; p1_if.addr = a; p1_if.wdata = d;
  endtask

  // Every output packed together: should be all-zero when idle.
  function automatic logic [63:0] all_outs();
    return 64'({p0_if.gnt, p1_if.gnt, p0_if.rvalid, p1_if.rvalid, ram_rd_ena, ram_wr_ena,
                (|ram_address), (|ram_wr_data), (|p0_if.rdata), (|p1_if.rdata)});
  endfunction

  logic exp_g0, exp_g1, prev_g0, prev_g1;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);

    // Reset state
    step(); step();
    settle();
    check("reset_outs", all_outs(), 64'd0);

    // Idle after reset
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); settle();
      check($sformatf("idle%0d", i), all_outs(), 64'd0);
    end

    // Port 0 write then read 0x010
    step();
    drive0(1'b1, 1'b1, 10'h010, 32'hDEADBEEF);
    settle();
    check("p0_wr_gnt", 64'({p0_if.gnt, ram_wr_ena, ram_rd_ena}), 64'b110);
    check("p0_wr_addr", 64'(ram_address), 64'h010);
    check("p0_wr_data", 64'(ram_wr_data), 64'hDEADBEEF);
    step();
    drive0(1'b1, 1'b0, 10'h010, 32'h0);
    settle();
    check("p0_rd_gnt", 64'({p0_if.gnt, ram_rd_ena, ram_wr_ena, p0_if.rvalid}), 64'b1100);
    step();
    drive0(1'b0, 1'b0, '0, '0);
    settle();
    check("p0_rvalid", 64'({p0_if.rvalid, p1_if.rvalid}), 64'b10);
    check("p0_rdata", 64'(p0_if.rdata), 64'hDEADBEEF);
    step(); settle();
    check("p0_rvalid_pulse", 64'({p0_if.rvalid, p0_if.rdata}), 64'd0);

    // Preload 0x001 / 0x002
    drive0(1'b1, 1'b1, 10'h001, 32'h11111111);
    settle();
    check("pre0_gnt", 64'(p0_if.gnt), 64'd1);
    step();
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b1, 1'b1, 10'h002, 32'h22222222);
    settle();
    check("pre1_gnt", 64'({p0_if.gnt, p1_if.gnt}), 64'b01);
    step();

    // Contended continuous reads
    drive0(1'b1, 1'b0, 10'h001, '0);
    drive1(1'b1, 1'b0, 10'h002, '0);
    prev_g0 = 1'b0;
    prev_g1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
`ifdef SP_RAM_ARB_RR_EN
      exp_g0 = (i % 2) == 0;
`else
      exp_g0 = 1'b1;
`endif
      exp_g1 = ~exp_g0;
      check($sformatf("cont_gnt%0d", i), 64'({p0_if.gnt, p1_if.gnt}), 64'({exp_g0, exp_g1}));
      check($sformatf("cont_rv%0d", i), 64'({p0_if.rvalid, p1_if.rvalid}), 64'({prev_g0, prev_g1}));
      if (prev_g0) check($sformatf("cont_rd0_%0d", i), 64'(p0_if.rdata), 64'h11111111);
      if (prev_g1) check($sformatf("cont_rd1_%0d", i), 64'(p1_if.rdata), 64'h22222222);
      prev_g0 = exp_g0;
      prev_g1 = exp_g1;
      step();
    end
    // Port 0 steps back; port 1 is served
    drive0(1'b0, 1'b0, '0, '0);
    settle();
    check("solo1_gnt", 64'({p0_if.gnt, p1_if.gnt}), 64'b01);
    check("solo1_rv", 64'({p0_if.rvalid, p1_if.rvalid}), 64'({prev_g0, prev_g1}));
    step();
    drive1(1'b0, 1'b0, '0, '0);
    settle();
    check("solo1_rvalid", 64'({p0_if.rvalid, p1_if.rvalid}), 64'b01);
    check("solo1_rdata", 64'(p1_if.rdata), 64'h22222222);
    step();

    // Cross-port write then read of 0x3FF
    drive1(1'b1, 1'b1, 10'h3FF, 32'h5A5A5A5A);
    settle();
    check("x_wr_gnt", 64'({p0_if.gnt, p1_if.gnt, ram_wr_ena}), 64'b011);
    step();
    drive1(1'b0, 1'b0, '0, '0);
    drive0(1'b1, 1'b0, 10'h3FF, '0);
    settle();
    check("x_rd_gnt", 64'({p0_if.gnt, p1_if.gnt, ram_rd_ena}), 64'b101);
    step();
    drive0(1'b0, 1'b0, '0, '0);
    settle();
    check("x_rdata", 64'({p0_if.rvalid, p0_if.rdata}), 64'({1'b1, 32'h5A5A5A5A}));
    step();

    // Reset mid-operation
    drive1(1'b1, 1'b0, 10'h002, '0);
    settle();
    check("r_p1_gnt", 64'(p1_if.gnt), 64'd1);
    step();
    rst = 1'b1;
    drive1(1'b0, 1'b0, '0, '0);
    drive0(1'b1, 1'b0, 10'h001, '0);
    settle();
    check("r_rv_first", 64'({p1_if.rvalid, p0_if.gnt, p1_if.gnt}), 64'b100);
    check("r_rdata_first", 64'(p1_if.rdata), 64'h22222222);
    step(); settle();
    check("r_rv_cleared", 64'({p1_if.rvalid, p0_if.gnt, ram_rd_ena}), 64'b000);
    step();
    rst = 1'b0;
    settle();
    check("r_held_gnt", 64'({p0_if.gnt, p1_if.gnt}), 64'b10);
    step();
    drive0(1'b0, 1'b0, '0, '0);
    settle();
    check("r_held_rdata", 64'({p0_if.rvalid, p0_if.rdata}), 64'({1'b1, 32'h11111111}));
    step(); settle();
    check("final_idle", all_outs(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
